// File: rtl/rgba_pkg.sv
// Shared definitions for the RGBA8888 -> RGB555/alpha packer: 16-bit field
// layout, opaque threshold, dither table and a saturating channel add.
package rgba_pkg;

  // 16-bit pixel layout. Bit 15 flags an alpha pixel. The three alpha bits
  // take the place of each channel's 5th bit.
  localparam int ALPHA_FLAG = 15;
  localparam int ALPHA_B2   = 10;
  localparam int ALPHA_B1   = 5;
  localparam int ALPHA_B0   = 0;
  localparam int R5_LSB     = 10;
  localparam int G5_LSB     = 5;
  localparam int B5_LSB     = 0;
  localparam int R4_LSB     = 11;
  localparam int G4_LSB     = 6;
  localparam int B4_LSB     = 1;

  // a3 value that marks a pixel as fully opaque
  localparam logic [2:0] OPAQUE_A3 = 3'd7;

  typedef enum logic {EMPTY, LO} pairState_e;

  typedef struct packed {
    logic [15:0] pix;
    logic        last;
  } s1Pix_t;

  // 2x2 ordered dither value indexed by {ybit, xbit}
  function automatic logic [1:0] ditherVal(input logic y, input logic x);
    case ({y, x})
      2'b00:   return 2'd0;
      2'b01:   return 2'd2;
      2'b10:   return 2'd3;
      default: return 2'd1;
    endcase
  endfunction

  // channel + offset, clamped at 255
  function automatic logic [7:0] satAdd(input logic [7:0] v, input logic [3:0] off);
    logic [8:0] s;
    s = {1'b0, v} + {5'b0, off};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/rgba_enc555.sv
// Combinational RGBA8888 -> 16-bit RGB555/alpha encoder. 'dith' is the
// ordered-dither value (0 gives pure truncation); opaque/alpha selection
// always looks at the raw alpha.
module rgba_enc555
  import rgba_pkg::*;
(
  input  logic [31:0] pix,
  input  logic [1:0]  dith,
  output logic [15:0] enc
);

  logic [2:0] a3;
  logic [3:0] off5, off4;
  logic [7:0] r5, g5, b5, r4, g4, b4;
  logic       unusedBits;

  // dither offset scales with the number of bits truncated away
  always_comb begin
    a3   = pix[31:29];
    off5 = {1'b0, dith, 1'b0};
    off4 = {dith, 2'b00};
    r5   = satAdd(pix[23:16], off5);
    g5   = satAdd(pix[15:8],  off5);
    b5   = satAdd(pix[7:0],   off5);
    r4   = satAdd(pix[23:16], off4);
    g4   = satAdd(pix[15:8],  off4);
    b4   = satAdd(pix[7:0],   off4);
  end

  // field packing: 5:5:5 when opaque, 4:4:4 plus alpha bits otherwise
  always_comb begin
    enc = '0;
    if (a3 == OPAQUE_A3) begin
      enc[R5_LSB +: 5] = r5[7:3];
      enc[G5_LSB +: 5] = g5[7:3];
      enc[B5_LSB +: 5] = b5[7:3];
    end else begin
      enc[ALPHA_FLAG]  = 1'b1;
      enc[R4_LSB +: 4] = r4[7:4];
      enc[ALPHA_B2]    = a3[2];
      enc[G4_LSB +: 4] = g4[7:4];
      enc[ALPHA_B1]    = a3[1];
      enc[B4_LSB +: 4] = b4[7:4];
      enc[ALPHA_B0]    = a3[0];
    end
  end

  assign unusedBits = ^{pix[28:24], r5[2:0], g5[2:0], b5[2:0],
                        r4[3:0], g4[3:0], b4[3:0]};

endmodule

// File: rtl/rgba_pack555.sv
// Streaming RGBA8888 -> RGB555/alpha encoder that packs two pixels per
// 32-bit word. S1 registers the encoded pixel, S2 pairs pixels into the
// output register. Optional 2x2 ordered dither: RGBA_PACK555_DITHER_EN.
module rgba_pack555
  import rgba_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pix,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [1:0]  out_mask,
  output logic        out_last
);

  logic        inAccept;
  logic [1:0]  dith;
  logic [15:0] encPix;
  logic        s1Valid;
  s1Pix_t      s1;
  pairState_e  state, stateNext;
  logic [15:0] loPix;
  logic        needEmit, s2Take, s2Emit;
  logic [31:0] emitWord;
  logic [1:0]  emitMask;

  assign inAccept = in_valid & in_ready;

`ifdef RGBA_PACK555_DITHER_EN
  logic xBit, yBit;

  // screen position parity: x restarts each line, y flips per line
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      xBit <= 1'b0;
      yBit <= 1'b0;
    end else if (inAccept) begin
      xBit <= in_last ? 1'b0 : ~xBit;
      if (in_last) yBit <= ~yBit;
    end

  assign dith = ditherVal(yBit, xBit);
`else
  assign dith = 2'd0;
`endif

  rgba_enc555 uEnc (
    .pix  (in_pix),
    .dith (dith),
    .enc  (encPix)
  );

  // S2 must emit when it completes a pair or sees a line end; it can only
  // do so if the output register is free or drains this cycle
  assign needEmit = (state == LO) | s1.last;
  assign s2Take   = s1Valid & (~needEmit | ~out_valid | out_ready);
  assign s2Emit   = s2Take & needEmit;
  assign in_ready = ~s1Valid | s2Take;

  // S1: registered encoder output
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      s1Valid <= 1'b0;
      s1      <= '0;
    end else if (inAccept) begin
      s1Valid <= 1'b1;
      s1      <= '{pix: encPix, last: in_last};
    end else if (s2Take) begin
      s1Valid <= 1'b0;
    end

  // pair state register
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= EMPTY;
    else        state <= stateNext;

  // pair next-state: hold a lone non-last pixel, release on its partner
  always_comb begin
    stateNext = state;
    if (s2Take) begin
      if (state == LO)   stateNext = EMPTY;
      else if (!s1.last) stateNext = LO;
    end
  end

  // word to emit for the current S2 step
  always_comb begin
    emitWord = {16'h0000, s1.pix};
    emitMask = 2'b01;
    if (state == LO) begin
      emitWord = {s1.pix, loPix};
      emitMask = 2'b11;
    end
  end

  // low-half holding register
  always_ff @(posedge clock or negedge reset)
    if (!reset)                                    loPix <= '0;
    else if (s2Take && state == EMPTY && !s1.last) loPix <= s1.pix;

  // output register: load on emission, otherwise clear valid once drained
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      out_valid <= 1'b0;
      out_word  <= '0;
      out_mask  <= '0;
      out_last  <= 1'b0;
    end else if (s2Emit) begin
      out_valid <= 1'b1;
      out_word  <= emitWord;
      out_mask  <= emitMask;
      out_last  <= s1.last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end

endmodule

// File: tb/tb_rgba_pack555.sv
// Directed + short random bench for rgba_pack555 with a scoreboard of
// expected output words built from an independent encoder/pairing model.
module tb_rgba_pack555;

  logic        clk = 1'b0;
  logic        rstN;
  logic        inValid, inReady, inLast;
  logic [31:0] inPix;
  logic        outValid, outReady, outLast;
  logic [31:0] outWord;
  logic [1:0]  outMask;

  typedef struct packed {
    logic [31:0] w;
    logic [1:0]  m;
    logic        l;
  } exp_t;

  exp_t        sbQ[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          popCount = 0;
  logic        hasLo = 1'b0;
  logic [15:0] loM = '0;
  logic        xb = 1'b0, yb = 1'b0;

  always #5 clk = ~clk;

  rgba_pack555 dut (
    .clock     (clk),
    .reset     (rstN),
    .in_valid  (inValid),
    .in_ready  (inReady),
    .in_pix    (inPix),
    .in_last   (inLast),
    .out_valid (outValid),
    .out_ready (outReady),
    .out_word  (outWord),
    .out_mask  (outMask),
    .out_last  (outLast)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int modelD();
`ifdef RGBA_PACK555_DITHER_EN
    case ({yb, xb})
      2'b00:   return 0;
      2'b01:   return 2;
      2'b10:   return 3;
      default: return 1;
    endcase
`else
    return 0;
`endif
  endfunction

  function automatic logic [15:0] encModel(input logic [31:0] p, input int d);
    int a, r5, g5, b5, r4, g4, b4, res;
    a  = int'(p[31:29]);
    r5 = sat(int'(p[23:16]) + 2 * d);
    g5 = sat(int'(p[15:8])  + 2 * d);
    b5 = sat(int'(p[7:0])   + 2 * d);
    r4 = sat(int'(p[23:16]) + 4 * d);
    g4 = sat(int'(p[15:8])  + 4 * d);
    b4 = sat(int'(p[7:0])   + 4 * d);
    if (a == 7)
      res = ((r5 >> 3) << 10) | ((g5 >> 3) << 5) | (b5 >> 3);
    else
      res = 32'h8000 | ((r4 >> 4) << 11) | (((a >> 2) & 1) << 10) |
            ((g4 >> 4) << 6) | (((a >> 1) & 1) << 5) | ((b4 >> 4) << 1) | (a & 1);
    return res[15:0];
  endfunction

  task automatic modelAccept(input logic [31:0] p, input logic l);
    logic [15:0] e;
    e = encModel(p, modelD());
    xb = l ? 1'b0 : ~xb;
    if (l) yb = ~yb;
    if (!hasLo && !l) begin
      hasLo = 1'b1;
      loM   = e;
    end else if (!hasLo) begin
      sbQ.push_back('{w: {16'h0000, e}, m: 2'b01, l: 1'b1});
    end else begin
      sbQ.push_back('{w: {e, loM}, m: 2'b11, l: l});
      hasLo = 1'b0;
    end
  endtask

  task automatic modelReset();
    sbQ.delete();
    hasLo = 1'b0;
    xb = 1'b0;
    yb = 1'b0;
  endtask

  // one clock: observe handshakes before the edge, end on the next negedge
  task automatic tick(output bit acc);
    bit   drn;
    exp_t e;
    #1;
    acc = inValid && inReady;
    drn = outValid && outReady;
    if (drn) begin
      chk("sb_nonempty", 32'(sbQ.size() != 0), 32'd1);
      if (sbQ.size() != 0) begin
        e = sbQ.pop_front();
        chk("out_word", outWord, e.w);
        chk("out_mask", 32'(outMask), 32'(e.m));
        chk("out_last", 32'(outLast), 32'(e.l));
        popCount++;
      end
    end
    if (acc) modelAccept(inPix, inLast);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic offer(input logic [31:0] p, input logic l);
    bit acc;
    acc = 1'b0;
    inValid = 1'b1;
    inPix   = p;
    inLast  = l;
    for (int i = 0; i < 20 && !acc; i++) tick(acc);
    chk("offer_accept", 32'(acc), 32'd1);
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    inValid  = 1'b0;
    outReady = 1'b1;
    for (int i = 0; i < 30 && sbQ.size() != 0; i++) tick(acc);
    chk("drain_empty", 32'(sbQ.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          acc;
    int          nAcc, pops0;
    logic [31:0] bpPix[6];
    bpPix = '{32'hFF102030, 32'h20405060, 32'hFFFFFFFF,
              32'h00000000, 32'hC0A5C3E7, 32'hFF7F7F7F};
    rstN = 1'b0; inValid = 1'b0; inPix = '0; inLast = 1'b0; outReady = 1'b0;
    #12;
    chk("rst_out_valid", 32'(outValid), 32'd0);
    chk("rst_out_word",  outWord,       32'd0);
    chk("rst_out_mask",  32'(outMask),  32'd0);
    chk("rst_out_last",  32'(outLast),  32'd0);
    chk("rst_in_ready",  32'(inReady),  32'd1);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);

    // opaque pair, back to back, with latency check
    outReady = 1'b1;
    inValid = 1'b1; inPix = 32'hFFF8FCF8; inLast = 1'b0;
    tick(acc); chk("pair_acc0", 32'(acc), 32'd1);
    inPix = 32'hFF000000;
    tick(acc); chk("pair_acc1", 32'(acc), 32'd1);
    inValid = 1'b0;
    chk("pair_lat_k1", 32'(outValid), 32'd0);
    tick(acc);
    chk("pair_lat_k2", 32'(outValid), 32'd1);
    chk("pair_word",   outWord,       32'h00007FFF);
    chk("pair_mask",   32'(outMask),  32'd3);
    chk("pair_last",   32'(outLast),  32'd0);
    drain();

    // alpha encoding, word closed by a last pixel
    offer(32'h80FF8010, 1'b0);
    offer(32'hFF000000, 1'b1);
    drain();

    // lone last pixel from EMPTY
    outReady = 1'b0;
    offer(32'hFFFF0000, 1'b1);
    tick(acc);
    chk("lone_valid", 32'(outValid), 32'd1);
    chk("lone_word",  outWord,       32'h00007C00);
    chk("lone_mask",  32'(outMask),  32'd1);
    chk("lone_last",  32'(outLast),  32'd1);
    drain();

    // backpressure: only four pixels fit
    outReady = 1'b0;
    nAcc = 0;
    pops0 = popCount;
    for (int c = 0; c < 6; c++) begin
      inValid = 1'b1; inPix = bpPix[nAcc]; inLast = 1'b0;
      tick(acc);
      if (acc) nAcc++;
    end
    #1;
    chk("bp_accepted", 32'(nAcc), 32'd4);
    chk("bp_in_ready", 32'(inReady), 32'd0);
    chk("bp_out_valid", 32'(outValid), 32'd1);
    chk("bp_hold_word0", outWord, sbQ[0].w);
    tick(acc); tick(acc);
    chk("bp_hold_word1", outWord, sbQ[0].w);
    chk("bp_hold_mask",  32'(outMask), 32'(sbQ[0].m));
    outReady = 1'b1;
    for (int c = 0; c < 20 && nAcc < 6; c++) begin
      inValid = 1'b1; inPix = bpPix[nAcc]; inLast = 1'b0;
      tick(acc);
      if (acc) nAcc++;
    end
    chk("bp_all_accepted", 32'(nAcc), 32'd6);
    drain();
    chk("bp_word_count", 32'(popCount - pops0), 32'd3);

    // reset mid-stream with LO held and a word pending
    outReady = 1'b0;
    offer(32'hFF112233, 1'b0);
    offer(32'hFF445566, 1'b0);
    offer(32'hFF778899, 1'b0);
    tick(acc);
    chk("mid_pre_valid", 32'(outValid), 32'd1);
    rstN = 1'b0;
    #1;
    chk("mid_out_valid", 32'(outValid), 32'd0);
    chk("mid_out_word",  outWord,       32'd0);
    chk("mid_out_mask",  32'(outMask),  32'd0);
    chk("mid_out_last",  32'(outLast),  32'd0);
    chk("mid_in_ready",  32'(inReady),  32'd1);
    modelReset();
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    outReady = 1'b1;
    offer(32'hFFAABBCC, 1'b0);
    offer(32'h40DDEEFF, 1'b0);
    drain();

    // dither on a fresh line (positions are back at 0 here)
    outReady = 1'b0;
    offer(32'hFF060606, 1'b0);
    offer(32'hFF060606, 1'b0);
    for (int i = 0; i < 5 && !outValid; i++) tick(acc);
`ifdef RGBA_PACK555_DITHER_EN
    chk("dither_word", outWord, 32'h04210000);
`else
    chk("dither_word", outWord, 32'h00000000);
`endif
    drain();

    // short random stream with random backpressure
    for (int c = 0; c < 80; c++) begin
      inValid  = 1'($urandom_range(0, 1));
      inPix    = $urandom;
      inLast   = ($urandom_range(0, 3) == 0);
      outReady = ($urandom_range(0, 3) != 0);
      tick(acc);
    end
    inValid = 1'b0;
    outReady = 1'b1;
    offer(32'hFF0F0F0F, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
